// File: rtl/txll_fis_wr_if.sv
// txll_fis_wr_if: request, payload, FIFO-write and frame-ready signals of the
// SATA TX frame writer. The slave modport is the frame writer itself; the
// master modport is the surrounding transport layer / FIFO side.
// Optional feature macro: TXLL_ABORT_EN (adds fis_abort).
interface txll_fis_wr_if #(
  parameter int C_LEN_W = 12
);
  logic               fis_req;
  logic [C_LEN_W-1:0] fis_len;
  logic               fis_ack;
  logic               fis_err;
  logic               fis_done;
  logic [31:0]        dat_di;
  logic               dat_valid;
  logic               dat_ready;
  logic               wr_en;
  logic [35:0]        wr_di;
  logic               wr_full;
  logic               rd_eof;
  logic               eof_rdy;
`ifdef TXLL_ABORT_EN
  logic               fis_abort;
`endif

  modport slave (
    input  fis_req, fis_len, dat_di, dat_valid, wr_full, rd_eof,
`ifdef TXLL_ABORT_EN
    input  fis_abort,
`endif
    output fis_ack, fis_err, fis_done, dat_ready, wr_en, wr_di, eof_rdy
  );

  modport master (
    output fis_req, fis_len, dat_di, dat_valid, wr_full, rd_eof,
`ifdef TXLL_ABORT_EN
    output fis_abort,
`endif
    input  fis_ack, fis_err, fis_done, dat_ready, wr_en, wr_di, eof_rdy
  );
endinterface

// File: rtl/txll_fis_wr.sv
// txll_fis_wr: SATA link-layer TX frame writer. Accepts a FIS request, tags
// the first/last payload dwords with sof/eof, writes 36-bit words into the TX
// FIFO and keeps a count of complete frames resident in that FIFO.
// Optional feature macro: TXLL_ABORT_EN (fis_abort input + ABORT state that
// closes a frame early with an eof+dsc word).
module txll_fis_wr #(
  parameter int C_LEN_W  = 12,
  parameter int C_FCNT_W = 4
) (
  input  logic         phyclk,
  input  logic         phyreset,
  output logic         wr_clk,
  txll_fis_wr_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1
`ifdef TXLL_ABORT_EN
    ,
    S_ABORT = 2'd2
`endif
  } state_t;

  localparam logic [C_FCNT_W-1:0] FCNT_MAX = '1;

  state_t              state;
  logic [C_LEN_W-1:0]  rem;
  logic                first;
  logic [C_FCNT_W-1:0] fcnt;
  logic                fis_ack_r;
  logic                fis_err_r;
  logic                eof_rdy_r;

  logic                len_ok;
  logic                last;
  logic                beat;
  logic                eof_wr;
  logic                dec;
  logic                dat_ready_c;
  logic                wr_en_c;
  logic [35:0]         wr_di_c;
  logic [C_FCNT_W-1:0] fcnt_nxt;

  assign wr_clk = phyclk;
  assign len_ok = (bus.fis_len != '0) && (32'(bus.fis_len) <= 32'd2048);
  assign last   = (rem == C_LEN_W'(1));
  assign beat   = (state == S_DATA) && bus.dat_valid && !bus.wr_full;
  assign dec    = bus.rd_eof && (fcnt != '0);

  // Zero-latency write path: payload passes straight to the FIFO on a beat;
  // the FIFO word is forced to zero whenever no write takes place.
  always_comb begin
    dat_ready_c = 1'b0;
    wr_en_c     = 1'b0;
    wr_di_c     = '0;
    eof_wr      = 1'b0;
    case (state)
      S_DATA: begin
        dat_ready_c = !bus.wr_full;
        if (beat) begin
          wr_en_c = 1'b1;
          wr_di_c = {first, last, 2'b00, bus.dat_di};
          eof_wr  = last;
        end
      end
`ifdef TXLL_ABORT_EN
      S_ABORT: begin
        if (!bus.wr_full) begin
          wr_en_c = 1'b1;
          wr_di_c = {first, 1'b1, 1'b1, 1'b0, 32'h0};
          eof_wr  = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Frame count: eof writes add a frame, rd_eof pops one; rd_eof at zero is ignored.
  always_comb begin
    fcnt_nxt = fcnt;
    if (eof_wr && !dec)
      fcnt_nxt = fcnt + C_FCNT_W'(1);
    else if (!eof_wr && dec)
      fcnt_nxt = fcnt - C_FCNT_W'(1);
  end

  // Request/frame FSM with registered ack/err and frame-ready flag. The ack
  // cycle is spent in IDLE so that dat_ready first rises the cycle after ack.
  always_ff @(posedge phyclk) begin
    if (phyreset) begin
      state     <= S_IDLE;
      rem       <= '0;
      first     <= 1'b0;
      fcnt      <= '0;
      fis_ack_r <= 1'b0;
      fis_err_r <= 1'b0;
      eof_rdy_r <= 1'b0;
    end else begin
      fis_ack_r <= 1'b0;
      fis_err_r <= 1'b0;
      fcnt      <= fcnt_nxt;
      eof_rdy_r <= (fcnt_nxt != '0);
      case (state)
        S_IDLE: begin
          if (fis_ack_r) begin
            state <= S_DATA;
          end else if (bus.fis_req) begin
            if (!len_ok) begin
              fis_err_r <= 1'b1;
            end else if (fcnt != FCNT_MAX) begin
              rem       <= bus.fis_len;
              first     <= 1'b1;
              fis_ack_r <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (beat) begin
            first <= 1'b0;
            rem   <= rem - C_LEN_W'(1);
          end
          if (beat && last)
            state <= S_IDLE;
`ifdef TXLL_ABORT_EN
          else if (bus.fis_abort)
            state <= S_ABORT;
`endif
        end
`ifdef TXLL_ABORT_EN
        S_ABORT: begin
          if (!bus.wr_full) begin
            state <= S_IDLE;
            first <= 1'b0;
            rem   <= '0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.fis_ack   = fis_ack_r;
  assign bus.fis_err   = fis_err_r;
  assign bus.fis_done  = eof_wr;
  assign bus.dat_ready = dat_ready_c;
  assign bus.wr_en     = wr_en_c;
  assign bus.wr_di     = wr_di_c;
  assign bus.eof_rdy   = eof_rdy_r;

endmodule

// File: tb/tb_txll_fis_wr.sv
// tb_txll_fis_wr: directed + randomized bench for txll_fis_wr. A queue holds
// the FIFO words each accepted frame must produce and an integer tracks the
// number of complete frames resident in the FIFO.
// Optional feature macro: TXLL_ABORT_EN (enables the abort scenario).
module tb_txll_fis_wr;

  logic phyclk;
  logic phyreset;
  logic wr_clk;

  txll_fis_wr_if #(.C_LEN_W(12)) bus ();

  txll_fis_wr #(.C_LEN_W(12), .C_FCNT_W(4)) dut (
    .phyclk   (phyclk),
    .phyreset (phyreset),
    .wr_clk   (wr_clk),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;
  int nwr    = 0;
  logic [35:0] expq [$];

  initial phyclk = 1'b0;
  always #5 phyclk = ~phyclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the next expected word, never happen
  // under wr_full, and fis_done must mark exactly the eof writes.
  always @(negedge phyclk) begin
    logic [35:0] w;
    logic        inc;
    if (phyreset) begin
      mcnt = 0;
      expq.delete();
    end else begin
      chk("eof_rdy", bus.eof_rdy, (mcnt != 0));
      inc = 1'b0;
      if (bus.wr_en) begin
        chk("wr_en_under_full", bus.wr_full, 1'b0);
        if (expq.size() == 0) begin
          chk("spurious_wr_en", bus.wr_en, 1'b0);
        end else begin
          w = expq.pop_front();
          chk("wr_di", bus.wr_di, w);
          inc = w[34];
          nwr++;
        end
      end
      chk("fis_done", bus.fis_done, inc);
      mcnt = mcnt + (inc ? 1 : 0) - ((bus.rd_eof && mcnt != 0) ? 1 : 0);
    end
  end

  // Raise fis_req for one cycle and require the registered ack one cycle later.
  task automatic accept(input int len);
    @(posedge phyclk); #1;
    bus.fis_req = 1'b1;
    bus.fis_len = 12'(len);
    @(negedge phyclk);
    chk("ack_early", bus.fis_ack, 1'b0);
    @(posedge phyclk); #1;
    bus.fis_req = 1'b0;
    @(negedge phyclk);
    chk("fis_ack", bus.fis_ack, 1'b1);
    chk("fis_err_on_ok", bus.fis_err, 1'b0);
  endtask

  // Drive nbeats payload beats of a len-dword frame.
  // full_mode: 0 never full, 1 toggles every 2 cycles, 2 random.
  // rd_mode:   0 no rd_eof, 1 rd_eof with the final beat, 2 random rd_eof.
  task automatic run_data(input int len, input int nbeats, input int full_mode,
                          input bit rnd_valid, input int rd_mode);
    logic [31:0] d [$];
    int i;
    int cyc;
    for (int k = 0; k < nbeats; k++) begin
      d.push_back($urandom);
      expq.push_back({(k == 0), (k == len - 1), 2'b00, d[k]});
    end
    i = 0;
    cyc = 0;
    while (i < nbeats) begin
      @(posedge phyclk); #1;
      bus.fis_req = 1'b0;
      case (full_mode)
        0:       bus.wr_full = 1'b0;
        1:       bus.wr_full = (((cyc / 2) % 2) == 1);
        default: bus.wr_full = ($urandom % 3 == 0);
      endcase
      bus.dat_valid = rnd_valid ? ($urandom % 4 != 0) : 1'b1;
      bus.dat_di    = bus.dat_valid ? d[i] : $urandom;
      case (rd_mode)
        1:       bus.rd_eof = (i == len - 1) && bus.dat_valid && !bus.wr_full;
        2:       bus.rd_eof = ($urandom % 4 == 0);
        default: bus.rd_eof = 1'b0;
      endcase
      @(negedge phyclk);
      chk("dat_ready", bus.dat_ready, !bus.wr_full);
      if (bus.dat_valid && !bus.wr_full) i++;
      cyc++;
    end
    @(posedge phyclk); #1;
    bus.dat_valid = 1'b0;
    bus.wr_full   = 1'b0;
    bus.rd_eof    = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge phyclk); #1;
      bus.rd_eof = 1'b1;
    end
    @(posedge phyclk); #1;
    bus.rd_eof = 1'b0;
  endtask

  task automatic bad_len(input int len);
    @(posedge phyclk); #1;
    bus.fis_req = 1'b1;
    bus.fis_len = 12'(len);
    @(posedge phyclk); #1;
    bus.fis_req = 1'b0;
    @(negedge phyclk);
    chk("fis_err_pulse", bus.fis_err, 1'b1);
    chk("fis_ack_on_err", bus.fis_ack, 1'b0);
    @(posedge phyclk); #1;
    @(negedge phyclk);
    chk("fis_err_single", bus.fis_err, 1'b0);
    chk("fis_ack_after_err", bus.fis_ack, 1'b0);
  endtask

  initial begin
    int n0;
    bit got;
    bus.fis_req   = 1'b0;
    bus.fis_len   = '0;
    bus.dat_di    = '0;
    bus.dat_valid = 1'b0;
    bus.wr_full   = 1'b0;
    bus.rd_eof    = 1'b0;
`ifdef TXLL_ABORT_EN
    bus.fis_abort = 1'b0;
`endif
    phyreset = 1'b1;
    repeat (3) @(posedge phyclk);
    #1;
    chk("wr_clk", wr_clk, phyclk);
    @(negedge phyclk);
    chk("rst_fis_ack", bus.fis_ack, 1'b0);
    chk("rst_fis_err", bus.fis_err, 1'b0);
    chk("rst_fis_done", bus.fis_done, 1'b0);
    chk("rst_dat_ready", bus.dat_ready, 1'b0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_wr_di", bus.wr_di, 36'h0);
    chk("rst_eof_rdy", bus.eof_rdy, 1'b0);
    @(posedge phyclk); #1;
    phyreset = 1'b0;

    // Four back-to-back beats; eof_rdy must follow one cycle after the eof write.
    accept(4);
    run_data(4, 4, 0, 1'b0, 0);
    @(negedge phyclk);
    chk("eof_rdy_after_frame", bus.eof_rdy, 1'b1);
    chk("queue_drained_4", expq.size(), 0);

    // Single-dword frame carries sof and eof together.
    accept(1);
    run_data(1, 1, 0, 1'b0, 0);
    chk("queue_drained_1", expq.size(), 0);

    // Illegal lengths.
    bad_len(0);
    bad_len(2049);

    // Eight beats under a toggling FIFO-full.
    n0 = nwr;
    accept(8);
    run_data(8, 8, 1, 1'b0, 0);
    chk("write_count_8", nwr - n0, 8);
    chk("queue_drained_8", expq.size(), 0);

    // Randomized frames with random valid, full and rd_eof.
    for (int f = 0; f < 6; f++) begin
      int len;
      len = $urandom_range(1, 12);
      accept(len);
      run_data(len, len, 2, 1'b1, 2);
    end
    chk("queue_drained_rand", expq.size(), 0);
    drain(16);
    @(negedge phyclk);
    chk("eof_rdy_drained", bus.eof_rdy, 1'b0);

    // Fill the frame counter to its limit; the next request must be held.
    for (int f = 0; f < 15; f++) begin
      int len;
      len = $urandom_range(1, 3);
      accept(len);
      run_data(len, len, 0, 1'b0, 0);
    end
    @(posedge phyclk); #1;
    bus.fis_req = 1'b1;
    bus.fis_len = 12'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge phyclk);
      chk("held_no_ack", bus.fis_ack, 1'b0);
      chk("held_no_err", bus.fis_err, 1'b0);
      @(posedge phyclk); #1;
    end
    bus.rd_eof = 1'b1;
    @(negedge phyclk);
    chk("held_no_ack_rd", bus.fis_ack, 1'b0);
    @(posedge phyclk); #1;
    bus.rd_eof = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 3 && !got; k++) begin
      @(negedge phyclk);
      if (bus.fis_ack) got = 1'b1;
      else begin
        @(posedge phyclk); #1;
      end
    end
    chk("held_ack_released", got, 1'b1);
    if (!got) bus.fis_req = 1'b0;
    // rd_eof coincides with this frame's eof write: 14 frames remain.
    run_data(2, 2, 0, 1'b0, 1);
    for (int k = 0; k < 13; k++) begin
      @(posedge phyclk); #1;
      bus.rd_eof = 1'b1;
    end
    @(posedge phyclk); #1;
    bus.rd_eof = 1'b0;
    @(negedge phyclk);
    chk("fcnt_one_left", bus.eof_rdy, 1'b1);
    @(posedge phyclk); #1;
    bus.rd_eof = 1'b1;
    @(posedge phyclk); #1;
    bus.rd_eof = 1'b0;
    @(negedge phyclk);
    chk("fcnt_empty", bus.eof_rdy, 1'b0);

`ifdef TXLL_ABORT_EN
    // Abort ignored in IDLE.
    @(posedge phyclk); #1;
    bus.fis_abort = 1'b1;
    @(posedge phyclk); #1;
    bus.fis_abort = 1'b0;
    @(negedge phyclk);
    chk("abort_idle_ready", bus.dat_ready, 1'b0);
    chk("abort_idle_wr", bus.wr_en, 1'b0);
    // Abort after two beats of a six-dword frame.
    accept(6);
    run_data(6, 2, 0, 1'b0, 0);
    bus.fis_abort = 1'b1;
    @(negedge phyclk);
    chk("abort_req_no_wr", bus.wr_en, 1'b0);
    @(posedge phyclk); #1;
    bus.fis_abort = 1'b0;
    expq.push_back({1'b0, 1'b1, 1'b1, 1'b0, 32'h0});
    @(negedge phyclk);
    chk("abort_wr_en", bus.wr_en, 1'b1);
    chk("abort_done", bus.fis_done, 1'b1);
    chk("abort_ready", bus.dat_ready, 1'b0);
    @(posedge phyclk); #1;
    @(negedge phyclk);
    chk("abort_eof_rdy", bus.eof_rdy, 1'b1);
    chk("queue_drained_abort", expq.size(), 0);
`endif

    // Leave a complete frame resident, then reset in the middle of another.
    accept(1);
    run_data(1, 1, 0, 1'b0, 0);
    accept(5);
    run_data(5, 2, 0, 1'b0, 0);
    phyreset = 1'b1;
    @(posedge phyclk); #1;
    @(negedge phyclk);
    chk("mid_rst_fis_ack", bus.fis_ack, 1'b0);
    chk("mid_rst_fis_err", bus.fis_err, 1'b0);
    chk("mid_rst_fis_done", bus.fis_done, 1'b0);
    chk("mid_rst_dat_ready", bus.dat_ready, 1'b0);
    chk("mid_rst_wr_en", bus.wr_en, 1'b0);
    chk("mid_rst_wr_di", bus.wr_di, 36'h0);
    chk("mid_rst_eof_rdy", bus.eof_rdy, 1'b0);
    @(posedge phyclk); #1;
    phyreset = 1'b0;
    bus.dat_valid = 1'b1;
    bus.dat_di    = $urandom;
    @(negedge phyclk);
    chk("idle_no_write", bus.wr_en, 1'b0);
    chk("idle_no_ready", bus.dat_ready, 1'b0);
    @(posedge phyclk); #1;
    bus.dat_valid = 1'b0;
    @(posedge phyclk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/txll_fis_wr.md
# txll_fis_wr

Transmit-side frame writer for the SATA link-layer TX path. Accepts a FIS request (length in dwords) plus a 32-bit data stream, tags the first and last words, and writes 36-bit words into the TX FIFO. The TX link-layer adapter drains that FIFO onto the trn_* interface. It also tracks how many complete frames sit in the FIFO and drives the frame-ready flag back to the read side.

## Interface

Parameters:
- C_LEN_W, 12: width of fis_len; legal lengths 1..2048 dwords.
- C_FCNT_W, 4: width of the complete-frame counter; at most 2^C_FCNT_W-1 frames outstanding.

Ports:
- phyclk  in  1  sole clock; all logic is rising-edge.
- phyreset  in  1  synchronous, active-high reset.
- fis_req  in  1  level; request to start a frame; sampled in IDLE only.
- fis_len  in  C_LEN_W  frame length in dwords; valid with fis_req.
- fis_ack  out  1  one-cycle pulse: request accepted.
- fis_err  out  1  one-cycle pulse: request rejected (fis_len==0 or >2048).
- fis_done  out  1  one-cycle pulse: eof word written.
- dat_di  in  32  payload dword.
- dat_valid  in  1  dat_di valid.
- dat_ready  out  1  block accepts dat_di this cycle.
- wr_clk  out  1  FIFO write clock, equal to phyclk.
- wr_en  out  1  FIFO write strobe.
- wr_di  out  36  FIFO word: [35]=sof, [34]=eof, [33]=dsc, [32]=0, [31:0]=data.
- wr_full  in  1  FIFO full.
- rd_eof  in  1  one-cycle pulse from the read side: an eof-tagged word was popped.
- eof_rdy  out  1  at least one complete frame is resident in the FIFO.
- fis_abort  in  1  present only with TXLL_ABORT_EN; see Configuration.

## Operation

- States: IDLE, DATA.
- IDLE:
  - dat_ready=0.
  - If fis_req=1 and fis_len is not in 1..2048: pulse fis_err and stay in IDLE.
  - Else if fis_req=1 and fcnt < max: latch rem=fis_len, set first=1, pulse fis_ack, go to DATA.
  - If fcnt==max: hold the request (no ack, no err) until fcnt drops.
- DATA:
  - dat_ready = ~wr_full (combinational).
  - Beat is defined as dat_valid & dat_ready; wr_en = beat.
  - wr_di = {first, rem==1, 1'b0, 1'b0, dat_di}.
  - On each beat: first←0 and rem←rem-1.
  - On a beat with rem==1: pulse fis_done (same cycle as the write), increment fcnt, go to IDLE.
- A single-dword frame writes one word with both sof and eof set.
- Frame counter fcnt (C_FCNT_W bits, registered):
  - Increments on an eof write and decrements on rd_eof.
  - Both in the same cycle: unchanged.
  - rd_eof with fcnt==0: ignored, no wrap.
- eof_rdy = (fcnt != 0), registered from fcnt.
- No word is ever written in IDLE; wr_en never asserts while wr_full=1.

## Timing

- Reset values:
  - state=IDLE, fcnt=0, rem=0, first=0.
  - fis_ack=0, fis_err=0, fis_done=0, eof_rdy=0.
  - dat_ready=0, wr_en=0, wr_di=0.
- fis_req→fis_ack latency: 1 cycle (registered). dat_ready can assert the cycle after fis_ack.
- Data path: zero latency. dat_di goes to wr_di combinationally with the beat; throughput is 1 dword/cycle while wr_full=0.
- eof_rdy rises 1 cycle after the eof write and falls 1 cycle after the rd_eof that empties fcnt.
- wr_full deasserts dat_ready in the same cycle. Data is held by the upstream until it is accepted.
- Reset mid-frame:
  - Returns to IDLE and clears fcnt with no further writes.
  - The FIFO is reset by the same phyreset; a partial frame left in it is the system's responsibility.

## Configuration

- TXLL_ABORT_EN defined:
  - Adds the fis_abort input and a third state, ABORT.
  - fis_abort=1 in DATA moves the block to ABORT on the next edge; dat_ready=0 in ABORT.
  - In ABORT, when wr_full=0: write one word {sof=first, eof=1, dsc=1, 0, 32'h0}, pulse fis_done, increment fcnt, go to IDLE.
  - fis_abort is ignored in IDLE.
  - fis_abort coincident with the final beat: the normal eof write wins and no abort word is written.
- TXLL_ABORT_EN undefined: no fis_abort port, no ABORT state, wr_di[33] is constant 0.

## Test plan

- Reset, then fis_len=4 with 4 back-to-back beats (D0..D3):
  - wr_di[35:34] sequence is 10,00,00,01.
  - fis_done pulses with D3.
  - eof_rdy=1 one cycle later.
- fis_len=1: a single write with wr_di[35:34]=11; fis_err stays 0.
- fis_len=0 and then fis_len=2049: fis_err pulses once each; no fis_ack, no wr_en.
- fis_len=8 with wr_full toggling every 2 cycles:
  - wr_en never asserts while wr_full=1.
  - Exactly 8 writes occur, with data order preserved.
- Frame counter:
  - Write 15 frames (fcnt=15); a 16th fis_req is held without ack.
  - A single rd_eof pulse lets the held request be acked next cycle.
  - rd_eof coincident with an eof write leaves fcnt unchanged.
- TXLL_ABORT_EN build: fis_len=6, abort after 2 beats:
  - The third write is {0,1,1,0,32'h0}.
  - fis_done pulses and fcnt increments.
  - phyreset asserted mid-frame afterwards: all outputs return to 0 next cycle.
